// File: rtl/cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_exc_ctrl
//
// Coprocessor-0 exception/interrupt sequencer for the pipelined MIPS core.
// Lives in the decode stage and drives the write side of the CP0 status, cause
// and EPC registers held by the decode-to-execute pipeline register. It also
// selects the exception/return fetch PC and produces the registered squash
// flag for the next D-stage instruction.
//
// Event priority (highest first): E-stage overflow, external interrupt,
// syscall, unimplemented instruction, eret, mtc0.
//
// Parameters:
//   EXC_BASE        exception vector address (the fetch mux selects it when
//                   selpc = 2'b10; it is not consumed inside this block)
//
// Ports:
//   clk             single clock
//   rst_n           synchronous reset, ACTIVE-HIGH despite the name
//   intr            external interrupt request (level, held until inta)
//   inta            interrupt acknowledge pulse
//   sta, cau, epc   current CP0 register values
//   pcd, pce, pcm   PCs of the D, E and M stage instructions
//   dbr, ebr        D / E instruction sits in a branch delay slot
//   is_syscall, is_unimpl, is_eret, is_mtc0   D-stage decode flags
//   c0sel           mtc0 target: 00 sta, 01 cau, 10 epc, 11 none
//   c0data          mtc0 write data
//   ov              E-stage overflow (already qualified by earith)
//   ecancel         the E instruction is cancelled
//   wsta/wcau/wepc  CP0 write enables
//   sta_in/cau_in/epc_in  CP0 write data
//   selpc           fetch PC source: 00 seq/branch, 01 epc, 10 EXC_BASE
//   cancel          registered squash flag for the next D instruction
//   kill_d, kill_e  suppress writes of the current D / E instruction
//
// Configuration macro:
//   CP0_INTR_SYNC_EN  defined: intr goes through a two-flop synchroniser.
//                     undefined: intr goes through a single register stage.
// -----------------------------------------------------------------------------
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_BASE = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        intr,
  output logic        inta,
  input  logic [31:0] sta,
  input  logic [31:0] cau,
  input  logic [31:0] epc,
  input  logic [31:0] pcd,
  input  logic [31:0] pce,
  input  logic [31:0] pcm,
  input  logic        dbr,
  input  logic        ebr,
  input  logic        is_syscall,
  input  logic        is_unimpl,
  input  logic        is_eret,
  input  logic        is_mtc0,
  input  logic [1:0]  c0sel,
  input  logic [31:0] c0data,
  input  logic        ov,
  input  logic        ecancel,
  output logic        wsta,
  output logic        wcau,
  output logic        wepc,
  output logic [31:0] sta_in,
  output logic [31:0] cau_in,
  output logic [31:0] epc_in,
  output logic [1:0]  selpc,
  output logic        cancel,
  output logic        kill_d,
  output logic        kill_e
);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  localparam logic [3:0] EXC_INT = 4'd0;
  localparam logic [3:0] EXC_SYS = 4'd8;
  localparam logic [3:0] EXC_UNI = 4'd9;
  localparam logic [3:0] EXC_OV  = 4'd12;

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       intr_s;

  // The current cause/EPC values and the vector address are consumed
  // elsewhere in the pipe; they are part of the port list for symmetry only.
  logic unused_ok;
  assign unused_ok = ^{cau, epc, EXC_BASE};

  // ---------------------------------------------------------------------------
  // Interrupt request synchroniser
  // ---------------------------------------------------------------------------
`ifdef CP0_INTR_SYNC_EN
  logic intr_meta;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value; blocking here would collapse the two stages into one.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      intr_meta <= 1'b0;
      intr_s    <= 1'b0;
    end else begin
      intr_meta <= intr;
      intr_s    <= intr_meta;
    end
  end
`else
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst_n) intr_s <= 1'b0;
    else       intr_s <= intr;
  end
`endif

  // ---------------------------------------------------------------------------
  // Event qualification
  // ---------------------------------------------------------------------------
  logic d_ok;
  logic ov_take, int_take, sys_take, uni_take, take;

  // D-stage events are only accepted in RUN: in FLUSH the D instruction is
  // being squashed. Overflow belongs to the older E instruction and is always
  // honoured.
  assign d_ok     = (state == S_RUN);
  assign ov_take  = ov & ~ecancel & sta[3];
  assign int_take = d_ok & intr_s & sta[0];
  assign sys_take = d_ok & is_syscall & sta[1];
  assign uni_take = d_ok & is_unimpl & sta[2];
  assign take     = ov_take | int_take | sys_take | uni_take;

  // ---------------------------------------------------------------------------
  // Output / next-state decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    wsta      = 1'b0;
    wcau      = 1'b0;
    wepc      = 1'b0;
    sta_in    = 32'h0;
    cau_in    = 32'h0;
    epc_in    = 32'h0;
    selpc     = 2'b00;
    kill_d    = 1'b0;
    kill_e    = 1'b0;
    inta      = 1'b0;
    state_nxt = S_RUN;

    // While reset is asserted everything stays at the idle defaults.
    if (!rst_n) begin
      if (take) begin
        wsta   = 1'b1;
        wcau   = 1'b1;
        wepc   = 1'b1;
        // Shift pushes the 4-bit mask stack and leaves all masks cleared.
        sta_in = sta << 4;
        selpc  = 2'b10;
        kill_d = 1'b1;
        kill_e = ov_take;
        inta   = int_take & ~ov_take;

        if (ov_take) begin
          cau_in = {26'b0, EXC_OV, 2'b00};
          // An overflowing delay-slot instruction restarts at its branch.
          epc_in = ebr ? pcm : pce;
        end else begin
          if (int_take)      cau_in = {26'b0, EXC_INT, 2'b00};
          else if (sys_take) cau_in = {26'b0, EXC_SYS, 2'b00};
          else               cau_in = {26'b0, EXC_UNI, 2'b00};
          epc_in = dbr ? pce : pcd;
        end
      end else if (d_ok && is_eret) begin
        wsta   = 1'b1;
        sta_in = sta >> 4;
        selpc  = 2'b01;
      end else if (d_ok && is_mtc0) begin
        case (c0sel)
          2'b00: begin
            wsta   = 1'b1;
            sta_in = c0data;
          end
          2'b01: begin
            wcau   = 1'b1;
            cau_in = c0data;
          end
          2'b10: begin
            wepc   = 1'b1;
            epc_in = c0data;
          end
          default: ;
        endcase
      end

      // FLUSH lasts exactly one cycle, even when an overflow is taken in it.
      if (d_ok && (take || is_eret)) state_nxt = S_FLUSH;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) state <= S_RUN;
    else       state <= state_nxt;
  end

  assign cancel = (state == S_FLUSH);

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_exc_ctrl
//
// Self-checking bench for cp0_exc_ctrl: a table of single-cycle vectors, each
// started from a fresh reset, followed by hand-written multi-cycle sequences
// (interrupt synchroniser latency, overflow vs interrupt, FLUSH behaviour,
// reset during FLUSH).
// -----------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

`ifdef CP0_INTR_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 1;
`endif

  localparam logic [31:0] PCD = 32'h40;
  localparam logic [31:0] PCE = 32'h20;
  localparam logic [31:0] PCM = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        intr, inta;
  logic [31:0] sta, cau, epc, pcd, pce, pcm;
  logic        dbr, ebr, is_syscall, is_unimpl, is_eret, is_mtc0;
  logic [1:0]  c0sel;
  logic [31:0] c0data;
  logic        ov, ecancel;
  logic        wsta, wcau, wepc;
  logic [31:0] sta_in, cau_in, epc_in;
  logic [1:0]  selpc;
  logic        cancel, kill_d, kill_e;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .intr(intr), .inta(inta),
    .sta(sta), .cau(cau), .epc(epc),
    .pcd(pcd), .pce(pce), .pcm(pcm), .dbr(dbr), .ebr(ebr),
    .is_syscall(is_syscall), .is_unimpl(is_unimpl), .is_eret(is_eret),
    .is_mtc0(is_mtc0), .c0sel(c0sel), .c0data(c0data),
    .ov(ov), .ecancel(ecancel),
    .wsta(wsta), .wcau(wcau), .wepc(wepc),
    .sta_in(sta_in), .cau_in(cau_in), .epc_in(epc_in),
    .selpc(selpc), .cancel(cancel), .kill_d(kill_d), .kill_e(kill_e)
  );

  typedef struct packed {
    logic [31:0] sta;
    logic [1:0]  br;     // {dbr, ebr}
    logic [3:0]  ev;     // {is_syscall, is_unimpl, is_eret, is_mtc0}
    logic [1:0]  c0sel;
    logic [31:0] c0data;
    logic [1:0]  oe;     // {ov, ecancel}
  } stim_t;

  typedef struct packed {
    logic [2:0]  wen;    // {wsta, wcau, wepc}
    logic [31:0] sta_in;
    logic [31:0] cau_in;
    logic [31:0] epc_in;
    logic [1:0]  selpc;
    logic [3:0]  flags;  // {kill_d, kill_e, inta, cancel}
  } resp_t;

  typedef struct {
    string name;
    stim_t s;
    resp_t r;            // flags[0] is the cancel expected after the edge
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  function automatic stim_t mk_s(input logic [31:0] s, input logic [1:0] br,
                                 input logic [3:0] ev, input logic [1:0] sel,
                                 input logic [31:0] d, input logic [1:0] oe);
    mk_s = '{sta: s, br: br, ev: ev, c0sel: sel, c0data: d, oe: oe};
  endfunction

  function automatic resp_t mk_r(input logic [2:0] wen, input logic [31:0] si,
                                 input logic [31:0] ci, input logic [31:0] ei,
                                 input logic [1:0] sel, input logic [3:0] fl);
    mk_r = '{wen: wen, sta_in: si, cau_in: ci, epc_in: ei, selpc: sel, flags: fl};
  endfunction

  function automatic resp_t sample();
    sample = '{wen: {wsta, wcau, wepc}, sta_in: sta_in, cau_in: cau_in,
               epc_in: epc_in, selpc: selpc,
               flags: {kill_d, kill_e, inta, cancel}};
  endfunction

  task automatic check(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    intr = 1'b0; sta = '0; cau = '0; epc = '0;
    pcd = PCD; pce = PCE; pcm = PCM;
    dbr = 1'b0; ebr = 1'b0;
    is_syscall = 1'b0; is_unimpl = 1'b0; is_eret = 1'b0; is_mtc0 = 1'b0;
    c0sel = 2'b11; c0data = '0; ov = 1'b0; ecancel = 1'b0;
  endtask

  task automatic drive(input stim_t s);
    sta = s.sta;
    {dbr, ebr} = s.br;
    {is_syscall, is_unimpl, is_eret, is_mtc0} = s.ev;
    c0sel = s.c0sel;
    c0data = s.c0data;
    {ov, ecancel} = s.oe;
  endtask

  // One reset edge, then release just after it.
  task automatic do_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  vec_t  vt[19];
  resp_t exp_r;

  initial begin
    clear_inputs();

    vt[0]  = '{"idle",         mk_s(32'h0,  2'b00, 4'b0000, 2'b00, 32'h0,    2'b00), mk_r(3'b000, 32'h0,   32'h0,    32'h0,    2'b00, 4'b0000)};
    vt[1]  = '{"ov_over_sys",  mk_s(32'h8,  2'b01, 4'b1000, 2'b00, 32'h0,    2'b10), mk_r(3'b111, 32'h80,  32'h30,   32'h100,  2'b10, 4'b1101)};
    vt[2]  = '{"ov_masked",    mk_s(32'h0,  2'b00, 4'b0000, 2'b00, 32'h0,    2'b10), mk_r(3'b000, 32'h0,   32'h0,    32'h0,    2'b00, 4'b0000)};
    vt[3]  = '{"ov_ecancel",   mk_s(32'h8,  2'b00, 4'b0000, 2'b00, 32'h0,    2'b11), mk_r(3'b000, 32'h0,   32'h0,    32'h0,    2'b00, 4'b0000)};
    vt[4]  = '{"ov_no_slot",   mk_s(32'h8,  2'b00, 4'b0000, 2'b00, 32'h0,    2'b10), mk_r(3'b111, 32'h80,  32'h30,   32'h20,   2'b10, 4'b1101)};
    vt[5]  = '{"sys_dslot",    mk_s(32'h2,  2'b10, 4'b1000, 2'b00, 32'h0,    2'b00), mk_r(3'b111, 32'h20,  32'h20,   32'h20,   2'b10, 4'b1001)};
    vt[6]  = '{"sys_masked",   mk_s(32'h0,  2'b10, 4'b1000, 2'b00, 32'h0,    2'b00), mk_r(3'b000, 32'h0,   32'h0,    32'h0,    2'b00, 4'b0000)};
    vt[7]  = '{"uni",          mk_s(32'h4,  2'b00, 4'b0100, 2'b00, 32'h0,    2'b00), mk_r(3'b111, 32'h40,  32'h24,   32'h40,   2'b10, 4'b1001)};
    vt[8]  = '{"sys_over_uni", mk_s(32'h6,  2'b00, 4'b1100, 2'b00, 32'h0,    2'b00), mk_r(3'b111, 32'h60,  32'h20,   32'h40,   2'b10, 4'b1001)};
    vt[9]  = '{"eret",         mk_s(32'h50, 2'b00, 4'b0010, 2'b00, 32'h0,    2'b00), mk_r(3'b100, 32'h5,   32'h0,    32'h0,    2'b01, 4'b0001)};
    vt[10] = '{"sys_over_eret",mk_s(32'h52, 2'b00, 4'b1010, 2'b00, 32'h0,    2'b00), mk_r(3'b111, 32'h520, 32'h20,   32'h40,   2'b10, 4'b1001)};
    vt[11] = '{"uni_drop_mtc0",mk_s(32'h4,  2'b00, 4'b0101, 2'b01, 32'hDEAD, 2'b00), mk_r(3'b111, 32'h40,  32'h24,   32'h40,   2'b10, 4'b1001)};
    vt[12] = '{"mtc0_cau",     mk_s(32'h4,  2'b00, 4'b0001, 2'b01, 32'hDEAD, 2'b00), mk_r(3'b010, 32'h0,   32'hDEAD, 32'h0,    2'b00, 4'b0000)};
    vt[13] = '{"mtc0_sta",     mk_s(32'h0,  2'b00, 4'b0001, 2'b00, 32'h1234, 2'b00), mk_r(3'b100, 32'h1234,32'h0,    32'h0,    2'b00, 4'b0000)};
    vt[14] = '{"mtc0_epc",     mk_s(32'h0,  2'b00, 4'b0001, 2'b10, 32'h5678, 2'b00), mk_r(3'b001, 32'h0,   32'h0,    32'h5678, 2'b00, 4'b0000)};
    vt[15] = '{"mtc0_none",    mk_s(32'h0,  2'b00, 4'b0001, 2'b11, 32'h5678, 2'b00), mk_r(3'b000, 32'h0,   32'h0,    32'h0,    2'b00, 4'b0000)};
    vt[16] = '{"eret_over_mtc0",mk_s(32'h50,2'b00, 4'b0011, 2'b01, 32'hDEAD, 2'b00), mk_r(3'b100, 32'h5,   32'h0,    32'h0,    2'b01, 4'b0001)};
    vt[17] = '{"ov_drop_mtc0", mk_s(32'h8,  2'b00, 4'b0001, 2'b10, 32'h99,   2'b10), mk_r(3'b111, 32'h80,  32'h30,   32'h20,   2'b10, 4'b1101)};
    vt[18] = '{"sys_ov_cancel",mk_s(32'hA,  2'b00, 4'b1000, 2'b00, 32'h0,    2'b11), mk_r(3'b111, 32'hA0,  32'h20,   32'h40,   2'b10, 4'b1001)};

    // ---- table-driven single-cycle vectors, each from a fresh reset ----
    for (int i = 0; i < 19; i++) begin
      clear_inputs();
      do_reset();
      drive(vt[i].s);
      #1;
      exp_r = vt[i].r;
      exp_r.flags[0] = 1'b0;                 // state is RUN before the edge
      check(vt[i].name, 128'(sample()), 128'(exp_r));
      @(posedge clk);
      #1;
      check({vt[i].name, "_cancel"}, 128'(cancel), 128'(vt[i].r.flags[0]));
    end

    // ---- interrupt: reset clears the synchroniser, then fixed latency ----
    begin
      int cyc;
      clear_inputs();
      sta = 32'h1;
      intr = 1'b1;
      do_reset();
      check("int_after_reset_inta", 128'(inta), 128'(1'b0));
      cyc = 0;
      for (int k = 1; k <= 8; k++) begin
        @(posedge clk);
        #1;
        if (inta) begin
          cyc = k;
          break;
        end
      end
      if (cyc == 0) cyc = 99;               // bound expired: reported below
      check("int_latency", 128'(cyc), 128'(SYNC));
      check("int_take", 128'(sample()),
            128'(mk_r(3'b111, 32'h10, 32'h0, 32'h40, 2'b10, 4'b1010)));
      @(posedge clk);
      #1;
      check("int_flush", 128'(sample()),
            128'(mk_r(3'b000, 32'h0, 32'h0, 32'h0, 2'b00, 4'b0001)));
      intr = 1'b0;
      sta = 32'h0;
    end

    // ---- overflow and interrupt in the same cycle: no acknowledge ----
    clear_inputs();
    sta = 32'h9;
    intr = 1'b1;
    do_reset();
    repeat (SYNC) @(posedge clk);
    #1 ov = 1'b1;
    #1;
    check("ov_over_int", 128'(sample()),
          128'(mk_r(3'b111, 32'h90, 32'h30, 32'h20, 2'b10, 4'b1100)));
    intr = 1'b0;
    ov = 1'b0;

    // ---- FLUSH: D events ignored, overflow still honoured ----
    clear_inputs();
    do_reset();
    sta = 32'h2; is_syscall = 1'b1; dbr = 1'b1;
    #1;
    check("flush_seed", 128'(sample()),
          128'(mk_r(3'b111, 32'h20, 32'h20, 32'h20, 2'b10, 4'b1000)));
    @(posedge clk);
    #1;
    check("flush_sys_ignored", 128'(sample()),
          128'(mk_r(3'b000, 32'h0, 32'h0, 32'h0, 2'b00, 4'b0001)));
    sta = 32'h8; ov = 1'b1; ebr = 1'b0;
    #1;
    check("flush_ov_taken", 128'(sample()),
          128'(mk_r(3'b111, 32'h80, 32'h30, 32'h20, 2'b10, 4'b1101)));
    ov = 1'b0;
    is_syscall = 1'b0;

    // ---- reset asserted during FLUSH ----
    clear_inputs();
    do_reset();
    sta = 32'h2; is_syscall = 1'b1;
    @(posedge clk);
    #1;
    check("rst_flush_entered", 128'(cancel), 128'(1'b1));
    rst_n = 1'b1;
    sta = 32'h8; ov = 1'b1; is_eret = 1'b1;
    #1;
    check("rst_outputs_idle", 128'(sample()),
          128'(mk_r(3'b000, 32'h0, 32'h0, 32'h0, 2'b00, 4'b0001)));
    @(posedge clk);
    #1;
    check("rst_cancel_cleared", 128'(sample()),
          128'(mk_r(3'b000, 32'h0, 32'h0, 32'h0, 2'b00, 4'b0000)));
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("rst_release_idle", 128'(sample()),
          128'(mk_r(3'b000, 32'h0, 32'h0, 32'h0, 2'b00, 4'b0000)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
